// File: rtl/key_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// key_cmd_scheduler
//   Merges the one-cycle key pulses from the button debouncers with an
//   internal gravity tick into a single ordered command stream for the game
//   FSM. Each source owns a pending latch; a round-robin arbiter moves at most
//   one pending source per cycle into a small FIFO, and the FIFO head is
//   offered to the consumer with a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_pulse  [0]LEFT [1]RIGHT [2]ROTATE [3]SOFT_DOWN [4]HARD_DROP pulses
//   enable     game running; low clears pending, flushes FIFO, parks gravity
//   level      speed level 0..15, shortens the gravity period
//   cmd_valid  FIFO head holds a command
//   cmd_code   head command: 0..4 key index, 5 gravity
//   cmd_ready  consumer takes the head when cmd_valid & cmd_ready
//   pending    pending latch per source (bit 5 = gravity)
//   dup_drop   sticky flag: a request arrived for an already-pending source
// -----------------------------------------------------------------------------
module key_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 25,
  parameter int GRAV_BASE  = 25_000_000,
  parameter int GRAV_STEP  = 2_000_000,
  parameter int GRAV_MIN   = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_pulse,
  input  logic       enable,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic [5:0] pending,
  output logic       dup_drop
);

  localparam int NSRC = 6;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] GRAV_SPAN = 32'(GRAV_BASE - GRAV_MIN);

  // ---------------------------------------------------------------- gravity
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lvl_step, period;
  logic             grav_fire;

  assign lvl_step = 32'(level) * 32'(GRAV_STEP);
  // Compare before subtracting so a large level can never wrap the period.
  assign period   = (lvl_step > GRAV_SPAN) ? 32'(GRAV_MIN) : 32'(GRAV_BASE) - lvl_step;
  // ">=" lets a level raised mid-count fire at once instead of wrapping.
  assign grav_fire = enable && (32'(cnt_q) >= (period - 32'd1));
  assign cnt_d     = (!enable || grav_fire) ? '0 : cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------- arbiter
  logic [5:0]  req, pend_q, pend_d, grant;
  logic [2:0]  ptr_q, ptr_d, grant_idx;
  logic [3:0]  scan_sum;
  logic        grant_vld, dup_q, dup_d;
  logic [AW:0] count_q, count_d;

  assign req = enable ? {grav_fire, key_pulse} : '0;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    // Registered count only: a pop this cycle does not open a slot when full.
    if (enable && (count_q < DEPTH_C)) begin
      for (int k = 0; k < NSRC; k++) begin
        scan_sum = {1'b0, ptr_q} + 4'(k);
        if (scan_sum >= 4'(NSRC)) scan_sum = scan_sum - 4'(NSRC);
        if (!grant_vld && pend_q[scan_sum[2:0]]) begin
          grant_vld = 1'b1;
          grant_idx = scan_sum[2:0];
        end
      end
    end
  end

  assign grant = grant_vld ? (6'b1 << grant_idx) : '0;

  // A request in the grant cycle re-arms the latch; one without a grant while
  // already pending is lost and flagged.
  assign pend_d = enable ? ((pend_q & ~grant) | req) : '0;
  assign dup_d  = dup_q | (|(req & pend_q & ~grant));
  assign ptr_d  = !grant_vld ? ptr_q :
                  (grant_idx == 3'(NSRC - 1)) ? 3'd0 : grant_idx + 3'd1;

  // ---------------------------------------------------------------- FIFO
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          push, pop;

  assign push = grant_vld;
  assign pop  = cmd_valid && cmd_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (!enable) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW + 1)'(1);
      else if (!push && pop) count_d = count_q - (AW + 1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      dup_q   <= 1'b0;
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dup_q   <= dup_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage is reset because cmd_code reads it directly and must
  // come out of reset as 0; at a few bits this costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= grant_idx;
    end
  end

  // Head is a flop output; it cannot change while the consumer stalls because
  // writes never target the occupied head slot.
  assign cmd_valid = (count_q != '0);
  assign cmd_code  = mem_q[rd_q];
  assign pending   = pend_q;
  assign dup_drop  = dup_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_key_cmd_scheduler
//   Directed bench for key_cmd_scheduler with a short gravity period
//   (base 20, step 4, floor 4). Inputs change 1 time unit after the rising
//   edge and outputs are sampled at the same point. Edge counts in comments
//   are numbered from the reset release that starts each scenario.
// -----------------------------------------------------------------------------
module tb_key_cmd_scheduler;

  logic       clk;
  logic       rst_n;
  logic [4:0] key_pulse;
  logic       enable;
  logic [3:0] level;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [5:0] pending;
  logic       dup_drop;

  int checks   = 0;
  int failures = 0;

  key_cmd_scheduler #(
    .FIFO_DEPTH(4),
    .CNT_W     (25),
    .GRAV_BASE (20),
    .GRAV_STEP (4),
    .GRAV_MIN  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_pulse(key_pulse),
    .enable   (enable),
    .level    (level),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .cmd_ready(cmd_ready),
    .pending  (pending),
    .dup_drop (dup_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then release with enable=1 using the current level/ready.
  task automatic restart();
    rst_n     = 1'b0;
    key_pulse = '0;
    enable    = 1'b0;
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  // Ticks until cmd_valid is seen; n = ticks taken (max if it never came).
  task automatic wait_cmd(input int max, output int n, output logic [2:0] code);
    n    = 0;
    code = 3'd7;
    while (n < max) begin
      tick();
      n++;
      if (cmd_valid) begin
        code = cmd_code;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [2:0]  code;
    int          bad_cmds;
    int          grav_cmds;
    logic [2:0]  exp4 [5];

    rst_n     = 1'b0;
    key_pulse = '0;
    enable    = 1'b0;
    level     = '0;
    cmd_ready = 1'b1;
    tick();
    tick();

    // ---- reset state
    check("rst_valid",   32'(cmd_valid), 0);
    check("rst_code",    32'(cmd_code),  0);
    check("rst_pending", 32'(pending),   0);
    check("rst_dup",     32'(dup_drop),  0);

    // ---- 1: single LEFT, two-cycle latency, valid for one cycle
    level = 4'd0;
    restart();
    key_pulse = 5'b00001;
    tick();                                   // e1: latch set
    key_pulse = '0;
    check("t1_pend_set",  32'(pending),   32'h01);
    check("t1_not_yet",   32'(cmd_valid), 0);
    tick();                                   // e2: granted and pushed
    check("t1_valid",     32'(cmd_valid), 1);
    check("t1_code",      32'(cmd_code),  0);
    check("t1_pend_clr",  32'(pending),   0);
    tick();                                   // e3: popped
    check("t1_one_cycle", 32'(cmd_valid), 0);

    // ---- 2: LEFT+ROTATE+HARD_DROP together from pointer 0
    restart();
    key_pulse = 5'b10101;
    tick();
    key_pulse = '0;
    check("t2_pend", 32'(pending), 32'h15);
    tick();
    check("t2_code0", 32'(cmd_code), 0);
    check("t2_pend0", 32'(pending),  32'h14);
    tick();
    check("t2_code2", 32'(cmd_code), 2);
    check("t2_pend2", 32'(pending),  32'h10);
    tick();
    check("t2_code4", 32'(cmd_code),  4);
    check("t2_valid", 32'(cmd_valid), 1);
    tick();
    check("t2_empty", 32'(cmd_valid), 0);
    check("t2_ptr",   32'(dut.ptr_q), 5);

    // ---- 3: stalled consumer, 6 sources (gravity period 8 at level 3)
    level     = 4'd3;
    cmd_ready = 1'b0;
    restart();
    key_pulse = 5'b11111;
    tick();                                   // e1
    key_pulse = '0;
    check("t3_pend_all", 32'(pending), 32'h1F);
    repeat (4) tick();                        // e2..e5: FIFO fills with 0..3
    check("t3_full_pend", 32'(pending), 32'h10);
    repeat (3) tick();                        // e8: gravity latched
    check("t3_pend_left", 32'(pending),   32'h30);
    check("t3_head",      32'(cmd_code),  0);
    check("t3_valid",     32'(cmd_valid), 1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_drain_v%0d", i), 32'(cmd_valid), 1);
      check($sformatf("t3_drain_c%0d", i), 32'(cmd_code),  32'(i));
      tick();
    end
    check("t3_drained", 32'(cmd_valid), 0);
    check("t3_no_dup",  32'(dup_drop),  0);

    // ---- 4: duplicate LEFT while the FIFO is full
    level     = 4'd0;
    cmd_ready = 1'b0;
    restart();
    key_pulse = 5'b01111;
    tick();                                   // e1
    key_pulse = '0;
    repeat (4) tick();                        // e2..e5: FIFO full
    check("t4_full_pend", 32'(pending), 0);
    key_pulse = 5'b00001;
    tick();                                   // e6: first LEFT latched
    key_pulse = '0;
    check("t4_first_dup", 32'(dup_drop), 0);
    check("t4_first_pnd", 32'(pending),  32'h01);
    tick();                                   // e7
    key_pulse = 5'b00001;
    tick();                                   // e8: second LEFT dropped
    key_pulse = '0;
    check("t4_dup_set", 32'(dup_drop), 1);
    check("t4_pend",    32'(pending),  32'h01);
    cmd_ready = 1'b1;
    exp4 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_drain_v%0d", i), 32'(cmd_valid), 1);
      check($sformatf("t4_drain_c%0d", i), 32'(cmd_code),  32'(exp4[i]));
      tick();
    end
    check("t4_one_left", 32'(cmd_valid), 0);
    check("t4_dup_held", 32'(dup_drop),  1);

    // ---- mid-operation asynchronous reset clears sticky state at once
    rst_n = 1'b0;
    #1;
    check("arst_dup",   32'(dup_drop),  0);
    check("arst_valid", 32'(cmd_valid), 0);

    // ---- 5: gravity periods
    level = 4'd0;
    restart();
    wait_cmd(40, n, code);
    check("t5_l0_first", 32'(n),    21);
    check("t5_l0_code",  32'(code), 5);
    wait_cmd(40, n, code);
    check("t5_l0_period", 32'(n),    20);
    check("t5_l0_code2",  32'(code), 5);

    level = 4'd15;
    restart();
    wait_cmd(40, n, code);
    check("t5_l15_first",  32'(n), 5);
    wait_cmd(40, n, code);
    check("t5_l15_period", 32'(n),    4);
    check("t5_l15_code",   32'(code), 5);

    level = 4'd0;
    restart();
    repeat (10) tick();                       // counter now 10
    check("t5_mid_quiet", 32'(cmd_valid), 0);
    level = 4'd4;
    wait_cmd(40, n, code);
    check("t5_mid_fire",   32'(n),    2);
    check("t5_mid_code",   32'(code), 5);
    wait_cmd(40, n, code);
    check("t5_mid_period", 32'(n),    4);

    // ---- 6: one-cycle disable flushes FIFO and pending, ignores keys
    level     = 4'd0;
    cmd_ready = 1'b0;
    restart();
    key_pulse = 5'b00111;
    tick();                                   // e1
    key_pulse = '0;
    tick();                                   // e2
    tick();                                   // e3
    key_pulse = 5'b01000;
    tick();                                   // e4: 3 queued, SOFT_DOWN pending
    key_pulse = '0;
    check("t6_pre_pend",  32'(pending),   32'h08);
    check("t6_pre_valid", 32'(cmd_valid), 1);
    enable    = 1'b0;
    key_pulse = 5'b00010;
    tick();                                   // e5: flush
    key_pulse = '0;
    enable    = 1'b1;
    cmd_ready = 1'b1;
    check("t6_flush_valid", 32'(cmd_valid), 0);
    check("t6_flush_pend",  32'(pending),   0);
    check("t6_ptr_kept",    32'(dut.ptr_q), 3);
    bad_cmds  = 0;
    grav_cmds = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_valid && cmd_code != 3'd5) bad_cmds++;
      if (cmd_valid && cmd_code == 3'd5) grav_cmds++;
    end
    check("t6_no_keys", 32'(bad_cmds),  0);
    check("t6_gravity", 32'(grav_cmds), 1);
    check("t6_dup",     32'(dup_drop),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
